alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Decode-and-issue stage that produces the ALU's control inputs: accepts 32-bit MIPS instruction words over a valid/ready handshake and decodes them into the 5-bit ALU operation code, shift amount, and immediate operand. It also emits the B-source select and overflow-check qualifier. Results are held in a 2-entry registered skid buffer, so the datapath can stall the ALU side without losing instructions. The block sits between instruction fetch and the ALU and drives the ALU's operation code and shift-amount inputs directly.

## Interface
- No parameters; all widths fixed (instruction 32, ALU code 5, shamt 5, immediate 32).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instr is valid this cycle
- in_ready  out  1  block can accept instr; in_ready = !skid_full && !flush
- instr  in  32  MIPS instruction word
- flush  in  1  synchronous; discards all held entries and the current input beat
- out_valid  out  1  output fields valid
- out_ready  in  1  consumer accepts output this cycle
- alu_ctr  out  5  ALU operation code
- shamt  out  5  instr[10:6] for R-type, else 0
- use_imm  out  1  1: ALU B operand = imm; 0: B = rt register
- imm  out  32  decoded immediate
- ovf_chk  out  1  1 for add, sub and addi; consumer gates the ALU OverFlow flag with it
- illegal  out  1  opcode/funct not decoded

## Operation
- An input beat transfers when in_valid && in_ready; an output beat transfers when out_valid && out_ready.
- R-type (opcode 0x00), funct to alu_ctr:
  - 0x20 to 0; 0x21 to 1; 0x22 to 2; 0x23 to 3
  - 0x24 to 4; 0x25 to 5; 0x26 to 6; 0x27 to 14
  - 0x00 to 8; 0x02 to 9; 0x03 to 11
  - 0x2A to 12; 0x2B to 13
  - 0x04 to 15; 0x06 to 16; 0x07 to 18 (see Configuration)
  - R-type sets use_imm=0 and imm=0.
- I-type, opcode to alu_ctr, with use_imm=1:
  - 0x08 to 0, sign-extended immediate
  - 0x09 to 1, sign-extended
  - 0x0A to 12, sign-extended
  - 0x0B to 13, sign-extended
  - 0x0C to 4, zero-extended
  - 0x0D to 5, zero-extended
  - 0x0E to 6, zero-extended
  - 0x0F (lui) to 30, imm = {instr[15:0],16'h0}
  - 0x23/0x2B (lw/sw) to 1, sign-extended
- Branches: 0x04/0x05 (beq/bne) to 3, use_imm=0, imm = sign-extended offset.
- Any other opcode/funct: alu_ctr=31, illegal=1, use_imm=0, imm=0, shamt=0, ovf_chk=0. The beat still flows through the buffer.
- Storage: main register (drives outputs) plus skid register. Occupancy is 0, 1 or 2:
  - Accept with main empty, or with main draining this cycle: decoded beat goes to main.
  - Accept while main is held (out_valid && !out_ready): decoded beat goes to skid; skid_full=1.
  - Skid full and out_ready: skid moves to main; skid empties; in_ready reasserts next cycle.
  - in_ready never depends on out_ready; it is registered from skid_full, then gated by flush.
- flush: main and skid are invalidated on the same edge; the input beat that cycle is not accepted. flush has priority over every other event.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on the outputs with out_valid=1 after edge N.
- Sustained throughput is 1 beat/cycle with out_ready held high.
- Outputs are stable while out_valid && !out_ready.
- Values during and right after reset:
  - out_valid=0, in_ready=1
  - alu_ctr=31
  - shamt=0, imm=0, use_imm=0, ovf_chk=0, illegal=0
  - Both entries empty.
- rst asserted mid-stall: all held beats are lost and outputs return to their reset values immediately (asynchronous).
- Simultaneous accept and drain at occupancy 1: the new beat replaces main; occupancy stays 1.
- Simultaneous accept and drain at occupancy 2: not possible, because in_ready=0.

## Configuration
- ALU_ISSUE_VAR_SHIFT_EN defined: funct 0x04/0x06/0x07 decode to 15/16/18 (sllv/srlv/srav), with shamt=0.
- ALU_ISSUE_VAR_SHIFT_EN undefined: those functs decode as illegal (alu_ctr=31, illegal=1).

## Test plan
- Reset, then instr=0x012A4020 (add $8,$9,$10) with out_ready=1 -> next cycle out_valid=1, alu_ctr=0, use_imm=0, ovf_chk=1, illegal=0.
- instr=0x2128FFFC (addi) -> alu_ctr=0, imm=0xFFFFFFFC, ovf_chk=1; instr=0x3528FFFC (ori) -> alu_ctr=5, imm=0x0000FFFC; instr=0x3C081234 (lui) -> alu_ctr=30, imm=0x12340000.
- instr=0x00094080 (sll $8,$9,2) -> alu_ctr=8, shamt=2; instr=0x01494004 (sllv) -> alu_ctr=15 with ALU_ISSUE_VAR_SHIFT_EN, else alu_ctr=31, illegal=1.
- out_ready=0 while streaming 3 beats -> beats 1 and 2 accepted, in_ready=0 after the second accept; release out_ready -> beats emerge in order 1,2,3 with no loss or duplication.
- Occupancy 2 with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears on the outputs.
- instr=0xFC000000 (undefined opcode) -> alu_ctr=31, illegal=1, imm=0; assert rst mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes MIPS instructions into ALU controls behind a 2-entry skid buffer.
// Define ALU_ISSUE_VAR_SHIFT_EN to decode sllv/srlv/srav; otherwise they decode as illegal.
module alu_op_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_ctr,
  output logic [4:0]  shamt,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        ovf_chk,
  output logic        illegal
);
  typedef struct packed {
    logic [4:0]  alu_ctr;
    logic [4:0]  shamt;
    logic        use_imm;
    logic [31:0] imm;
    logic        ovf_chk;
    logic        illegal;
  } fields_t;
  localparam fields_t RST_F = fields_t'({5'd31, 40'd0});
  function automatic fields_t f(input logic [4:0] c, input logic u, input logic [31:0] i, input logic o);
    return {c, 5'd0, u, i, o, 1'b0};
  endfunction
  logic [5:0]  op, fn;
  logic [4:0]  rc;
  logic [31:0] sx, zx;
  fields_t     dec, main_q, skid_q;
  logic        main_v, skid_v, accept, unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign sx = {{16{instr[15]}}, instr[15:0]};
  assign zx = {16'h0, instr[15:0]};
  assign unused_bits = ^instr[25:16];
  always_comb begin
    rc = 5'd31;
    case (fn)
      6'h20: rc = 5'd0;
      6'h21: rc = 5'd1;
      6'h22: rc = 5'd2;
      6'h23: rc = 5'd3;
      6'h24: rc = 5'd4;
      6'h25: rc = 5'd5;
      6'h26: rc = 5'd6;
      6'h27: rc = 5'd14;
      6'h00: rc = 5'd8;
      6'h02: rc = 5'd9;
      6'h03: rc = 5'd11;
      6'h2A: rc = 5'd12;
      6'h2B: rc = 5'd13;
`ifdef ALU_ISSUE_VAR_SHIFT_EN
      6'h04: rc = 5'd15;
      6'h06: rc = 5'd16;
      6'h07: rc = 5'd18;
`endif
      default: rc = 5'd31;
    endcase
  end
  // codes above 14 are the variable shifts, which take their amount from rs
  always_comb begin
    dec = fields_t'({5'd31, 39'd0, 1'b1});
    case (op)
      6'h00: if (rc != 5'd31) dec = {rc, rc > 5'd14 ? 5'd0 : instr[10:6], 1'b0, 32'd0, fn == 6'h20 || fn == 6'h22, 1'b0};
      6'h08: dec = f(5'd0, 1'b1, sx, 1'b1);
      6'h09: dec = f(5'd1, 1'b1, sx, 1'b0);
      6'h0A: dec = f(5'd12, 1'b1, sx, 1'b0);
      6'h0B: dec = f(5'd13, 1'b1, sx, 1'b0);
      6'h0C: dec = f(5'd4, 1'b1, zx, 1'b0);
      6'h0D: dec = f(5'd5, 1'b1, zx, 1'b0);
      6'h0E: dec = f(5'd6, 1'b1, zx, 1'b0);
      6'h0F: dec = f(5'd30, 1'b1, {instr[15:0], 16'h0}, 1'b0);
      6'h23, 6'h2B: dec = f(5'd1, 1'b1, sx, 1'b0);
      6'h04, 6'h05: dec = f(5'd3, 1'b0, sx, 1'b0);
      default: ;
    endcase
  end
  assign in_ready  = !skid_v && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = main_v;
  assign {alu_ctr, shamt, use_imm, imm, ovf_chk, illegal} = main_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= RST_F;
      skid_q <= RST_F;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (out_ready) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (accept && main_v && !out_ready) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end else if (accept) begin
      main_q <= dec;
      main_v <= 1'b1;
    end else if (out_ready) begin
      main_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed and randomized checks of alu_op_issue against a queue-based model.
module tb_alu_op_issue;
  logic        clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        use_imm, ovf_chk, illegal;
  logic [31:0] instr, imm;
  logic [4:0]  alu_ctr, shamt;
  int          total = 0, bad = 0;
  typedef struct packed {
    logic [4:0]  c;
    logic [4:0]  s;
    logic        u;
    logic [31:0] i;
    logic        o;
    logic        il;
  } exp_t;
  exp_t q[$];
`ifdef ALU_ISSUE_VAR_SHIFT_EN
  localparam bit VS = 1'b1;
`else
  localparam bit VS = 1'b0;
`endif
  logic [5:0] fns [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00,
                           6'h02, 6'h03, 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
  logic [5:0] ops [16] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h00, 6'h02, 6'h3F, 6'h10};

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_ctr(alu_ctr),
    .shamt(shamt), .use_imm(use_imm), .imm(imm), .ovf_chk(ovf_chk), .illegal(illegal)
  );

  function automatic exp_t mk(input logic [4:0] c, input logic [4:0] s, input logic u,
                              input logic [31:0] i, input logic o, input logic il);
    return {c, s, u, i, o, il};
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    logic [31:0] sx, zx;
    logic [4:0]  sa;
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0, w[15:0]};
    sa = w[10:6];
    model = mk(5'd31, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20: model = mk(5'd0,  sa, 1'b0, 32'd0, 1'b1, 1'b0);
        6'h21: model = mk(5'd1,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h22: model = mk(5'd2,  sa, 1'b0, 32'd0, 1'b1, 1'b0);
        6'h23: model = mk(5'd3,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h24: model = mk(5'd4,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h25: model = mk(5'd5,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h26: model = mk(5'd6,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h27: model = mk(5'd14, sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h00: model = mk(5'd8,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h02: model = mk(5'd9,  sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h03: model = mk(5'd11, sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h2A: model = mk(5'd12, sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h2B: model = mk(5'd13, sa, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h04: if (VS) model = mk(5'd15, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h06: if (VS) model = mk(5'd16, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        6'h07: if (VS) model = mk(5'd18, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        default: ;
      endcase
    end else begin
      case (w[31:26])
        6'h08: model = mk(5'd0,  5'd0, 1'b1, sx, 1'b1, 1'b0);
        6'h09: model = mk(5'd1,  5'd0, 1'b1, sx, 1'b0, 1'b0);
        6'h0A: model = mk(5'd12, 5'd0, 1'b1, sx, 1'b0, 1'b0);
        6'h0B: model = mk(5'd13, 5'd0, 1'b1, sx, 1'b0, 1'b0);
        6'h0C: model = mk(5'd4,  5'd0, 1'b1, zx, 1'b0, 1'b0);
        6'h0D: model = mk(5'd5,  5'd0, 1'b1, zx, 1'b0, 1'b0);
        6'h0E: model = mk(5'd6,  5'd0, 1'b1, zx, 1'b0, 1'b0);
        6'h0F: model = mk(5'd30, 5'd0, 1'b1, {w[15:0], 16'h0}, 1'b0, 1'b0);
        6'h23, 6'h2B: model = mk(5'd1, 5'd0, 1'b1, sx, 1'b0, 1'b0);
        6'h04, 6'h05: model = mk(5'd3, 5'd0, 1'b0, sx, 1'b0, 1'b0);
        default: ;
      endcase
    end
  endfunction

  // drive one cycle from a negedge, advance the model, return at the next negedge
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    logic acc;
    in_valid = v; instr = w; out_ready = rdy; flush = fl;
    acc = v && q.size() < 2 && !fl;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back(model(w));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_hs got=%b want=01", {out_valid, in_ready});
    end
    total++;
    if ({alu_ctr, shamt, use_imm, imm, ovf_chk, illegal} !== {5'd31, 40'd0}) begin
      bad++; $display("FAIL reset_fields got=%h want=%h", {alu_ctr, shamt, use_imm, imm, ovf_chk, illegal}, {5'd31, 40'd0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode;
    logic [31:0] w [6] = '{32'h012A4020, 32'h2128FFFC, 32'h3528FFFC, 32'h3C081234, 32'h00094080, 32'h01494004};
    exp_t e [6];
    e[0] = mk(5'd0,  5'd0, 1'b0, 32'd0,        1'b1, 1'b0);
    e[1] = mk(5'd0,  5'd0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
    e[2] = mk(5'd5,  5'd0, 1'b1, 32'h0000FFFC, 1'b0, 1'b0);
    e[3] = mk(5'd30, 5'd0, 1'b1, 32'h12340000, 1'b0, 1'b0);
    e[4] = mk(5'd8,  5'd2, 1'b0, 32'd0,        1'b0, 1'b0);
    e[5] = VS ? mk(5'd15, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0) : mk(5'd31, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, w[k], 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || {alu_ctr, shamt, use_imm, imm, ovf_chk, illegal} !== e[k]) begin
        bad++; $display("FAIL decode_%0d instr=%h got v=%b %h want v=1 %h", k, w[k], out_valid,
                        {alu_ctr, shamt, use_imm, imm, ovf_chk, illegal}, e[k]);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL decode_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] want [6] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd4, 5'd0};
    logic [1:0] hs   [6] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
    logic [31:0] a = 32'h012A4020, b = 32'h012A4022, c = 32'h012A4024;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: cycle(1'b1, a, 1'b0, 1'b0);
        1: cycle(1'b1, b, 1'b0, 1'b0);
        2: cycle(1'b1, c, 1'b0, 1'b0);
        3: cycle(1'b1, c, 1'b1, 1'b0);
        4: cycle(1'b1, c, 1'b1, 1'b0);
        default: cycle(1'b0, '0, 1'b1, 1'b0);
      endcase
      total++;
      if ({out_valid, in_ready} !== hs[k] || (hs[k][1] && alu_ctr !== want[k])) begin
        bad++; $display("FAIL stall_%0d got v/r=%b ctr=%0d want v/r=%b ctr=%0d", k, {out_valid, in_ready}, alu_ctr, hs[k], want[k]);
      end
    end
  endtask

  task automatic test_flush;
    cycle(1'b1, 32'h012A4020, 1'b0, 1'b0);
    cycle(1'b1, 32'h012A4022, 1'b0, 1'b0);
    in_valid = 1'b1; instr = 32'h012A4025; flush = 1'b1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b want=0", in_ready); end
    @(negedge clk);
    cycle(1'b1, 32'h012A4025, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_after got=%b want=01", {out_valid, in_ready});
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak got=%b want=0", out_valid); end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, 32'hFC000000, 1'b1, 1'b0);
    total++;
    if ({out_valid, alu_ctr, illegal, imm} !== {1'b1, 5'd31, 1'b1, 32'd0}) begin
      bad++; $display("FAIL undef got v=%b ctr=%0d ill=%b imm=%h want v=1 ctr=31 ill=1 imm=0", out_valid, alu_ctr, illegal, imm);
    end
    cycle(1'b1, 32'h012A4020, 1'b0, 1'b0);
    cycle(1'b1, 32'h012A4022, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    total++;
    if ({out_valid, in_ready, alu_ctr, illegal} !== {1'b0, 1'b1, 5'd31, 1'b0}) begin
      bad++; $display("FAIL async_rst got v=%b r=%b ctr=%0d ill=%b want v=0 r=1 ctr=31 ill=0", out_valid, in_ready, alu_ctr, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] r, w;
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0: w = {6'h00, r[25:6], fns[$urandom_range(0, 17)]};
        1: w = {ops[$urandom_range(0, 15)], r[25:0]};
        default: w = r;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2 && !flush)) begin
        bad++; $display("FAIL rand_hs_%0d got v=%b r=%b want occ=%0d fl=%b", k, out_valid, in_ready, q.size(), flush);
      end
      if (q.size() > 0) begin
        total++;
        if ({alu_ctr, shamt, use_imm, imm, ovf_chk, illegal} !== q[0]) begin
          bad++; $display("FAIL rand_data_%0d got=%h want=%h", k, {alu_ctr, shamt, use_imm, imm, ovf_chk, illegal}, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
